// File: rtl/alu_control_seq.sv
// alu_control_seq: registered ALU control decoder with a multi-cycle MULT/DIV sequencer.
// Latency: 1 cycle from accept to out_valid/alu_control/muldiv_start.
// Backpressure: in_ready drops for the whole BUSY phase; in_valid is ignored while busy.
// Optional feature: define ALU_CTRL_SHIFT_EN to decode the R-type shift functions.
module alu_control_seq #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [5:0] func_i,
    input  logic [1:0] alu_op_i,
    output logic       out_valid_o,
    output logic [3:0] alu_control_o,
    output logic       err_illegal_func_code_o,
    output logic       err_illegal_alu_op_o,
    output logic       muldiv_start_o,
    output logic       muldiv_is_div_o,
    output logic       muldiv_signed_o,
    output logic       muldiv_busy_o,
    output logic       muldiv_done_o
);

    // Counter must hold the larger of the two reload values.
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // Counter is loaded with N-1 so that BUSY spans exactly N cycles.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ALU select encoding.
    localparam logic [3:0] CTRL_AND    = 4'b0000;
    localparam logic [3:0] CTRL_OR     = 4'b0001;
    localparam logic [3:0] CTRL_ADD    = 4'b0010;
    localparam logic [3:0] CTRL_SUB    = 4'b0110;
    localparam logic [3:0] CTRL_SLT    = 4'b0111;
    localparam logic [3:0] CTRL_NOR    = 4'b1100;
    localparam logic [3:0] CTRL_MULDIV = 4'b1111;
`ifdef ALU_CTRL_SHIFT_EN
    localparam logic [3:0] CTRL_SLL    = 4'b1000;
    localparam logic [3:0] CTRL_SRL    = 4'b1001;
    localparam logic [3:0] CTRL_SRA    = 4'b1010;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid_q;
    logic [3:0]       alu_control_q;
    logic             err_func_q;
    logic             err_op_q;
    logic             start_q;
    logic             is_div_q;
    logic             signed_q;
    logic             done_q;

    // Combinational decode of the current request.
    logic [3:0] ctrl_d;
    logic       func_err_d;
    logic       op_err_d;
    logic       is_md_d;
    logic       md_div_d;
    logic       md_signed_d;
    logic       accept;

    // Ready is a pure function of state so upstream sees it without a decode path.
    assign in_ready_o = (state_q != ST_BUSY);
    assign accept     = in_valid_i & in_ready_o;

    // Decode {alu_op, func} into ALU select, error flags and muldiv kind.
    always_comb begin
        ctrl_d      = CTRL_ADD;
        func_err_d  = 1'b0;
        op_err_d    = 1'b0;
        is_md_d     = 1'b0;
        md_div_d    = 1'b0;
        md_signed_d = 1'b0;
        unique case (alu_op_i)
            2'b00: ctrl_d = CTRL_ADD;
            2'b01: ctrl_d = CTRL_SUB;
            2'b10: begin
                unique case (func_i)
                    6'b100000, 6'b100001: ctrl_d = CTRL_ADD;
                    6'b100010, 6'b100011: ctrl_d = CTRL_SUB;
                    6'b100100:            ctrl_d = CTRL_AND;
                    6'b100101:            ctrl_d = CTRL_OR;
                    6'b100111:            ctrl_d = CTRL_NOR;
                    6'b101010, 6'b101011: ctrl_d = CTRL_SLT;
                    6'b001000:            ctrl_d = CTRL_ADD;  // jr uses the adder
                    6'b011000: begin  // MULT
                        ctrl_d      = CTRL_MULDIV;
                        is_md_d     = 1'b1;
                        md_signed_d = 1'b1;
                    end
                    6'b011001: begin  // MULTU
                        ctrl_d  = CTRL_MULDIV;
                        is_md_d = 1'b1;
                    end
                    6'b011010: begin  // DIV
                        ctrl_d      = CTRL_MULDIV;
                        is_md_d     = 1'b1;
                        md_div_d    = 1'b1;
                        md_signed_d = 1'b1;
                    end
                    6'b011011: begin  // DIVU
                        ctrl_d   = CTRL_MULDIV;
                        is_md_d  = 1'b1;
                        md_div_d = 1'b1;
                    end
`ifdef ALU_CTRL_SHIFT_EN
                    6'b000000, 6'b000100: ctrl_d = CTRL_SLL;
                    6'b000010, 6'b000110: ctrl_d = CTRL_SRL;
                    6'b000011, 6'b000111: ctrl_d = CTRL_SRA;
`endif
                    default: begin
                        ctrl_d     = CTRL_ADD;
                        func_err_d = 1'b1;
                    end
                endcase
            end
            default: begin
                // alu_op 11: flag the opcode only, never start the muldiv unit.
                ctrl_d   = CTRL_ADD;
                op_err_d = 1'b1;
            end
        endcase
    end

    // Sequencer FSM plus all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            alu_control_q <= 4'b0000;
            err_func_q    <= 1'b0;
            err_op_q      <= 1'b0;
            start_q       <= 1'b0;
            is_div_q      <= 1'b0;
            signed_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // Per-accept pulses; cleared on any cycle without an accept.
            out_valid_q <= accept;
            err_func_q  <= accept & func_err_d;
            err_op_q    <= accept & op_err_d;
            start_q     <= accept & is_md_d;
            done_q      <= 1'b0;

            // alu_control holds its last decoded value between accepts.
            if (accept) begin
                alu_control_q <= ctrl_d;
            end

            // A muldiv accept latches the operation kind and loads the counter.
            // Accept can never coincide with BUSY, so this never fights the decrement.
            if (accept && is_md_d) begin
                is_div_q <= md_div_d;
                signed_q <= md_signed_d;
                cnt_q    <= md_div_d ? DIV_LOAD : MUL_LOAD;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (accept && is_md_d) begin
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Counter parks at zero; it is only reloaded by a new start.
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    // Back-to-back muldiv may be accepted in the DONE cycle.
                    state_q <= (accept && is_md_d) ? ST_BUSY : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid_o             = out_valid_q;
    assign alu_control_o           = alu_control_q;
    assign err_illegal_func_code_o = err_func_q;
    assign err_illegal_alu_op_o    = err_op_q;
    assign muldiv_start_o          = start_q;
    assign muldiv_is_div_o         = is_div_q;
    assign muldiv_signed_o         = signed_q;
    assign muldiv_busy_o           = (state_q == ST_BUSY);
    assign muldiv_done_o           = done_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq (default parameters MUL=4, DIV=32).
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
module tb_alu_control_seq;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [5:0] func_i;
    logic [1:0] alu_op_i;
    logic       out_valid_o;
    logic [3:0] alu_control_o;
    logic       err_illegal_func_code_o;
    logic       err_illegal_alu_op_o;
    logic       muldiv_start_o;
    logic       muldiv_is_div_o;
    logic       muldiv_signed_o;
    logic       muldiv_busy_o;
    logic       muldiv_done_o;

    int total = 0;
    int bad   = 0;

    alu_control_seq dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .in_valid_i              (in_valid_i),
        .in_ready_o              (in_ready_o),
        .func_i                  (func_i),
        .alu_op_i                (alu_op_i),
        .out_valid_o             (out_valid_o),
        .alu_control_o           (alu_control_o),
        .err_illegal_func_code_o (err_illegal_func_code_o),
        .err_illegal_alu_op_o    (err_illegal_alu_op_o),
        .muldiv_start_o          (muldiv_start_o),
        .muldiv_is_div_o         (muldiv_is_div_o),
        .muldiv_signed_o         (muldiv_signed_o),
        .muldiv_busy_o           (muldiv_busy_o),
        .muldiv_done_o           (muldiv_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request for exactly one edge, then drop valid.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn);
        in_valid_i = 1'b1;
        alu_op_i   = op;
        func_i     = fn;
        cyc();
        in_valid_i = 1'b0;
    endtask

    // Check the decode result of the request accepted on the last edge.
    task automatic chk_dec(input string tag, input logic [3:0] ctrl,
                           input logic ef, input logic eo, input logic st);
        chk({tag, ".valid"}, {7'd0, out_valid_o}, 8'd1);
        chk({tag, ".ctrl"}, {4'd0, alu_control_o}, {4'd0, ctrl});
        chk({tag, ".errf"}, {7'd0, err_illegal_func_code_o}, {7'd0, ef});
        chk({tag, ".erro"}, {7'd0, err_illegal_alu_op_o}, {7'd0, eo});
        chk({tag, ".start"}, {7'd0, muldiv_start_o}, {7'd0, st});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, {7'd0, out_valid_o}, 8'd0);
        chk({tag, ".ctrl"}, {4'd0, alu_control_o}, 8'd0);
        chk({tag, ".errf"}, {7'd0, err_illegal_func_code_o}, 8'd0);
        chk({tag, ".erro"}, {7'd0, err_illegal_alu_op_o}, 8'd0);
        chk({tag, ".start"}, {7'd0, muldiv_start_o}, 8'd0);
        chk({tag, ".isdiv"}, {7'd0, muldiv_is_div_o}, 8'd0);
        chk({tag, ".sgn"}, {7'd0, muldiv_signed_o}, 8'd0);
        chk({tag, ".busy"}, {7'd0, muldiv_busy_o}, 8'd0);
        chk({tag, ".done"}, {7'd0, muldiv_done_o}, 8'd0);
        chk({tag, ".rdy"}, {7'd0, in_ready_o}, 8'd1);
    endtask

    logic [5:0] sweep_fn   [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000};
    logic [3:0] sweep_ctrl [6] = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111,   4'b0010};

    initial begin
        rst_i      = 1'b1;
        in_valid_i = 1'b0;
        func_i     = 6'd0;
        alu_op_i   = 2'd0;

        // 1: reset held two cycles, then a mem-type add ignoring func.
        cyc();
        cyc();
        rst_i = 1'b0;
        chk_all_zero("reset");
        issue(2'b00, 6'b101010);
        chk_dec("mem_add", 4'b0010, 1'b0, 1'b0, 1'b0);
        issue(2'b01, 6'b111111);
        chk_dec("branch_sub", 4'b0110, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("idle.valid", {7'd0, out_valid_o}, 8'd0);
        chk("idle.hold_ctrl", {4'd0, alu_control_o}, 8'h06);

        // 2: R-type sweep, back-to-back accepts, then an illegal func.
        for (int i = 0; i < 6; i++) begin
            issue(2'b10, sweep_fn[i]);
            chk_dec($sformatf("rtype%0d", i), sweep_ctrl[i], 1'b0, 1'b0, 1'b0);
        end
        issue(2'b10, 6'b111010);
        chk_dec("bad_func", 4'b0010, 1'b1, 1'b0, 1'b0);

        // 3: illegal alu_op.
        issue(2'b11, 6'b111111);
        chk_dec("bad_op", 4'b0010, 1'b0, 1'b1, 1'b0);
        chk("bad_op.busy", {7'd0, muldiv_busy_o}, 8'd0);
        cyc();
        chk("bad_op.clear", {7'd0, err_illegal_alu_op_o}, 8'd0);

        // 4: DIV; 32 busy cycles follow the accept edge, done in the 33rd cycle.
        issue(2'b10, 6'b011010);
        chk_dec("div", 4'b1111, 1'b0, 1'b0, 1'b1);
        chk("div.isdiv", {7'd0, muldiv_is_div_o}, 8'd1);
        chk("div.sgn", {7'd0, muldiv_signed_o}, 8'd1);
        for (int i = 1; i <= 32; i++) begin
            // Offer an add during busy; it must be ignored. Withdrawn before DONE.
            in_valid_i = (i < 32);
            alu_op_i   = 2'b00;
            func_i     = 6'b000000;
            chk($sformatf("div.busy%0d", i), {7'd0, muldiv_busy_o}, 8'd1);
            chk($sformatf("div.rdy%0d", i), {7'd0, in_ready_o}, 8'd0);
            chk($sformatf("div.done%0d", i), {7'd0, muldiv_done_o}, 8'd0);
            chk($sformatf("div.ctrl%0d", i), {4'd0, alu_control_o}, 8'h0f);
            if (i > 1) begin
                chk($sformatf("div.valid%0d", i), {7'd0, out_valid_o}, 8'd0);
                chk($sformatf("div.start%0d", i), {7'd0, muldiv_start_o}, 8'd0);
            end
            cyc();
        end
        in_valid_i = 1'b0;
        chk("div.done", {7'd0, muldiv_done_o}, 8'd1);
        chk("div.busy_end", {7'd0, muldiv_busy_o}, 8'd0);
        chk("div.rdy_done", {7'd0, in_ready_o}, 8'd1);
        chk("div.hold_isdiv", {7'd0, muldiv_is_div_o}, 8'd1);
        cyc();
        chk("div.done_pulse", {7'd0, muldiv_done_o}, 8'd0);
        chk("div.idle_busy", {7'd0, muldiv_busy_o}, 8'd0);
        chk("div.idle_valid", {7'd0, out_valid_o}, 8'd0);

        // 5: MULTU, back-to-back MULT in the DONE cycle, reset mid-busy.
        issue(2'b10, 6'b011001);
        chk_dec("multu", 4'b1111, 1'b0, 1'b0, 1'b1);
        chk("multu.isdiv", {7'd0, muldiv_is_div_o}, 8'd0);
        chk("multu.sgn", {7'd0, muldiv_signed_o}, 8'd0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("multu.busy%0d", i), {7'd0, muldiv_busy_o}, 8'd1);
            chk($sformatf("multu.rdy%0d", i), {7'd0, in_ready_o}, 8'd0);
            cyc();
        end
        chk("multu.done", {7'd0, muldiv_done_o}, 8'd1);
        chk("multu.rdy_done", {7'd0, in_ready_o}, 8'd1);
        issue(2'b10, 6'b011000);
        chk_dec("mult_b2b", 4'b1111, 1'b0, 1'b0, 1'b1);
        chk("mult_b2b.sgn", {7'd0, muldiv_signed_o}, 8'd1);
        chk("mult_b2b.isdiv", {7'd0, muldiv_is_div_o}, 8'd0);
        chk("mult_b2b.busy", {7'd0, muldiv_busy_o}, 8'd1);
        chk("mult_b2b.done", {7'd0, muldiv_done_o}, 8'd0);
        cyc();
        chk("mult_b2b.busy2", {7'd0, muldiv_busy_o}, 8'd1);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        chk_all_zero("abort");
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("abort.nodone%0d", i), {7'd0, muldiv_done_o}, 8'd0);
            chk($sformatf("abort.nobusy%0d", i), {7'd0, muldiv_busy_o}, 8'd0);
            cyc();
        end

        // 6: SRA function, legal only with the shift feature.
        issue(2'b10, 6'b000011);
`ifdef ALU_CTRL_SHIFT_EN
        chk_dec("sra", 4'b1010, 1'b0, 1'b0, 1'b0);
`else
        chk_dec("sra", 4'b0010, 1'b1, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
